debounce_pair: RTL and testbench
================================

Name: debounce_pair

Overview:
- Input-conditioning stage that sits directly upstream of the behavioural logic-gate blocks (and_gate and siblings).
- Takes two raw, asynchronous, possibly bouncing inputs and synchronises each one to clk.
- Debounces each channel independently and presents clean, stable levels for the gate's A and B inputs.
- Emits a one-cycle change strobe whenever either clean level updates, so a downstream monitor or checker can sample the gate output.

Parameters:
- STABLE_CYCLES, 8: consecutive cycles a synchronised input must differ from its clean level before the clean level updates. Legal range is 1 or more.
- CNT_W, 4: width of each channel's stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_raw  input  1  raw channel A, asynchronous to clk
- b_raw  input  1  raw channel B, asynchronous to clk
- a_clean  output  1  debounced, registered channel A (drives gate input A)
- b_clean  output  1  debounced, registered channel B (drives gate input B)
- change  output  1  registered one-cycle pulse when a_clean or b_clean updates
- glitch_cnt  output  8  present only with GLITCH_CNT_EN (see Optional Feature)

Behaviour:
- Reset:
  - rst_n low clears everything immediately, regardless of clk: both synchroniser stages, both counters, a_clean=0, b_clean=0, change=0, glitch_cnt=0.
  - Deassertion takes effect at the next rising edge.
- Synchroniser:
  - Each channel uses two flops, raw->s1->s2.
  - Only s2 is used by the logic below.
- Per-channel counter (cnt), evaluated every edge:
  - If s2 == clean: cnt <= 0 and clean holds. A mismatch that ends early is discarded with no partial credit.
  - If s2 != clean and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If s2 != clean and cnt == STABLE_CYCLES-1: clean <= s2 and cnt <= 0.
- Latency:
  - A raw level change held steady appears on clean at the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
  - With the default STABLE_CYCLES=8 this is edge 10.
  - STABLE_CYCLES=1 gives a latency of 3 edges.
- change:
  - Registered; asserted on the same edge that either clean output updates.
  - Low on every other edge.
  - If both channels update on the same edge, change is a single one-cycle pulse.
  - change is never high for two consecutive cycles unless the channels update on consecutive edges.
- Channels are fully independent; activity on one never affects the other's counter.
- Bounce: any return of s2 to the clean value before the count completes restarts the count from 0 on the next mismatch.
- Reset mid-count: the pending count is lost. After release a still-differing input needs the full latency again, measured from the first post-reset sampling edge.
- No combinational path from raw inputs to any output.

Optional Feature:
- Macro: GLITCH_CNT_EN.
- Defined:
  - Adds the glitch_cnt output, an 8-bit counter shared by both channels.
  - It increments by 1 on each edge where a channel's cnt is nonzero and s2 returns equal to clean (a rejected glitch).
  - If both channels reject on the same edge, it increments by 2.
  - It saturates at 255 and clears only on reset.
- Not defined: the glitch_cnt port and all associated logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with a_raw=b_raw=1 -> a_clean=b_clean=change=0 immediately; glitch_cnt=0 when enabled.
- Clean rise: STABLE_CYCLES=8, a_raw 0->1 held 20 cycles -> a_clean rises at edge 10 after the first sampling edge; change high for exactly that cycle; b_clean stays 0.
- Glitch rejection: a_raw high for 5 cycles then low -> a_clean stays 0, change never asserts; glitch_cnt=1 when enabled.
- Simultaneous: a_raw and b_raw both 0->1 on the same cycle, held -> both clean outputs rise on the same edge (edge 10); one single-cycle change pulse.
- Bounce then settle: a_raw pattern 3 high, 2 low, 3 high, 1 low, then steady high -> a_clean rises at edge 10 counted from the start of the steady-high period; glitch_cnt=2 when enabled.
- Reset mid-count: a_raw held high, rst_n pulsed low at count 6 -> a_clean=0; after release a_clean rises 10 edges after the first post-reset edge.

Source files
------------

// File: rtl/debounce_pair.sv
// Two-channel synchronise-and-debounce front end for gate inputs A/B with a shared change strobe.
// Optional feature macro: GLITCH_CNT_EN adds an 8-bit saturating rejected-glitch counter output.
module debounce_pair #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_clean,
    output logic       b_clean,
    output logic       change
`ifdef GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0]       w_raw;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_clean;
    logic [1:0]       w_clean_d;
    logic [1:0]       w_update;
    logic [CNT_W-1:0] r_cnt   [2];
    logic [CNT_W-1:0] w_cnt_d [2];
    logic             r_change;

    assign w_raw = {b_raw, a_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_clean_d = r_clean;
        w_update  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_cnt_d[i] = '0;
            if (r_s2[i] != r_clean[i]) begin
                if (r_cnt[i] == CntMax) begin
                    w_clean_d[i] = r_s2[i];
                    w_update[i]  = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
            r_clean  <= 2'b00;
            r_change <= 1'b0;
        end else begin
            r_cnt[0] <= w_cnt_d[0];
            r_cnt[1] <= w_cnt_d[1];
            r_clean  <= w_clean_d;
            r_change <= |w_update;
        end
    end

    assign a_clean = r_clean[0];
    assign b_clean = r_clean[1];
    assign change  = r_change;

`ifdef GLITCH_CNT_EN
    logic [1:0] w_reject;
    logic [1:0] w_glitch_inc;
    logic [8:0] w_glitch_sum;
    logic [7:0] r_glitch;

    // A glitch is a mismatch run that ended before the count completed.
    assign w_reject[0]  = (r_cnt[0] != '0) && (r_s2[0] == r_clean[0]);
    assign w_reject[1]  = (r_cnt[1] != '0) && (r_s2[1] == r_clean[1]);
    assign w_glitch_inc = {1'b0, w_reject[0]} + {1'b0, w_reject[1]};
    assign w_glitch_sum = {1'b0, r_glitch} + {7'b0, w_glitch_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch <= 8'd0;
        end else begin
            r_glitch <= w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
        end
    end

    assign glitch_cnt = r_glitch;
`endif

endmodule

// File: tb/tb_debounce_pair.sv
// Directed self-checking bench for debounce_pair at the default STABLE_CYCLES=8.
module tb_debounce_pair;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_clean;
    logic b_clean;
    logic change;
`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_tests;
    int n_fail;
    logic seen_change;

    debounce_pair dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .change  (change)
`ifdef GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a_raw   = 1'b0;
        b_raw   = 1'b0;

        // Reset state
        steps(2);
        check("reset_a_clean", {7'b0, a_clean}, 8'd0);
        check("reset_b_clean", {7'b0, b_clean}, 8'd0);
        check("reset_change", {7'b0, change}, 8'd0);
`ifdef GLITCH_CNT_EN
        check("reset_glitch", glitch_cnt, 8'd0);
`endif
        rst_n = 1'b1;
        steps(3);

        // Clean rise on A
        a_raw = 1'b1;
        steps(9);
        check("rise_e9_a", {7'b0, a_clean}, 8'd0);
        check("rise_e9_change", {7'b0, change}, 8'd0);
        step();
        check("rise_e10_a", {7'b0, a_clean}, 8'd1);
        check("rise_e10_change", {7'b0, change}, 8'd1);
        check("rise_e10_b", {7'b0, b_clean}, 8'd0);
        step();
        check("rise_e11_change", {7'b0, change}, 8'd0);
        check("rise_e11_a", {7'b0, a_clean}, 8'd1);
        steps(9);
        check("rise_hold_b", {7'b0, b_clean}, 8'd0);
        a_raw = 1'b0;
        steps(12);
        check("fall_a", {7'b0, a_clean}, 8'd0);

        // Glitch rejection: 5 cycles high then low
        seen_change = 1'b0;
        a_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_change = seen_change | change;
        end
        a_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen_change = seen_change | change;
        end
        check("glitch_a", {7'b0, a_clean}, 8'd0);
        check("glitch_change", {7'b0, seen_change}, 8'd0);
`ifdef GLITCH_CNT_EN
        check("glitch_cnt1", glitch_cnt, 8'd1);
`endif

        // Simultaneous rise on A and B
        a_raw = 1'b1;
        b_raw = 1'b1;
        steps(9);
        check("sim_e9_a", {7'b0, a_clean}, 8'd0);
        check("sim_e9_b", {7'b0, b_clean}, 8'd0);
        step();
        check("sim_e10_a", {7'b0, a_clean}, 8'd1);
        check("sim_e10_b", {7'b0, b_clean}, 8'd1);
        check("sim_e10_change", {7'b0, change}, 8'd1);
        step();
        check("sim_e11_change", {7'b0, change}, 8'd0);
        a_raw = 1'b0;
        b_raw = 1'b0;
        steps(12);
        check("sim_fall_a", {7'b0, a_clean}, 8'd0);
        check("sim_fall_b", {7'b0, b_clean}, 8'd0);

        // Bounce then settle: 3 high, 2 low, 3 high, 1 low, steady high
        a_raw = 1'b1;
        steps(3);
        a_raw = 1'b0;
        steps(2);
        a_raw = 1'b1;
        steps(3);
        a_raw = 1'b0;
        steps(1);
        a_raw = 1'b1;
        steps(9);
        check("bounce_e9_a", {7'b0, a_clean}, 8'd0);
        step();
        check("bounce_e10_a", {7'b0, a_clean}, 8'd1);
        check("bounce_e10_change", {7'b0, change}, 8'd1);
`ifdef GLITCH_CNT_EN
        check("bounce_glitch", glitch_cnt, 8'd3);
`endif
        a_raw = 1'b0;
        steps(12);
        check("bounce_fall_a", {7'b0, a_clean}, 8'd0);

        // Reset mid-count with both raws high
        a_raw = 1'b1;
        b_raw = 1'b1;
        steps(8);
        rst_n = 1'b0;
        #2;
        check("midrst_a", {7'b0, a_clean}, 8'd0);
        check("midrst_b", {7'b0, b_clean}, 8'd0);
        check("midrst_change", {7'b0, change}, 8'd0);
`ifdef GLITCH_CNT_EN
        check("midrst_glitch", glitch_cnt, 8'd0);
`endif
        #1;
        rst_n = 1'b1;
        steps(9);
        check("midrst_e9_a", {7'b0, a_clean}, 8'd0);
        step();
        check("midrst_e10_a", {7'b0, a_clean}, 8'd1);
        check("midrst_e10_b", {7'b0, b_clean}, 8'd1);
        check("midrst_e10_change", {7'b0, change}, 8'd1);

        // Asynchronous reset clears settled-high outputs immediately
        steps(3);
        rst_n = 1'b0;
        #2;
        check("async_a", {7'b0, a_clean}, 8'd0);
        check("async_b", {7'b0, b_clean}, 8'd0);
        check("async_change", {7'b0, change}, 8'd0);
        steps(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
